// File: rtl/dmem_subsystem_if.sv
// rtl/dmem_subsystem_if.sv - core-to-data-memory bus bundle for dmem_subsystem
//
// Purpose: groups the single-cycle core's data-side signals.
// Signals:
//   memory_address  core -> mem  byte address
//   data_to_write   core -> mem  unshifted store data (rs2)
//   func3           core -> mem  store width (000 SB, 001 SH, 010 SW)
//   write_data      core -> mem  store strobe
//   read_data       mem -> core  aligned word at memory_address
//   halt            mem -> core  sticky halt
//   tohost_value    mem -> core  last value stored to TOHOST
//   store_error     mem -> core  sticky store error
interface dmem_subsystem_if;
   logic [31:0] memory_address;
   logic [31:0] data_to_write;
   logic [2:0]  func3;
   logic        write_data;
   logic [31:0] read_data;
   logic        halt;
   logic [31:0] tohost_value;
   logic        store_error;

   modport master (
      output memory_address, data_to_write, func3, write_data,
      input  read_data, halt, tohost_value, store_error
   );

   modport slave (
      input  memory_address, data_to_write, func3, write_data,
      output read_data, halt, tohost_value, store_error
   );
endinterface

// File: rtl/dmem_subsystem.sv
// rtl/dmem_subsystem.sv - data RAM, cycle counter, tohost halt and store error tracking
//
// Purpose: data-side memory for a single-cycle RV32I core. Reads are
// combinational whole aligned words; stores merge byte lanes on the rising edge.
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  asynchronous active-high reset
//   bus  dmem_subsystem_if.slave (address, store data/width/strobe in;
//        read_data, halt, tohost_value, store_error out)
module dmem_subsystem #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input logic              clk,
   input logic              rst,
   dmem_subsystem_if.slave  bus
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   state_t      state_q, state_d;
   logic        halt_q, halt_d;
   logic [63:0] cycle_q, cycle_d;
   logic [31:0] tohost_q, tohost_d;
   logic [7:0]  mis_cnt_q, mis_cnt_d;
   logic        unmapped_q, unmapped_d;
   logic        illegal_q, illegal_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [31:0] addr;
   logic        in_ram, in_mmio;
   logic [AW-1:0] word_idx;
   logic [1:0]  reg_sel;
   logic        f3_legal, misaligned;
   logic [3:0]  be;
   logic [31:0] wd;
   logic        ram_we;
   logic [31:0] status;
   logic [31:0] rd;

   assign addr     = bus.memory_address;
   assign in_ram   = (addr >> (AW + 2)) == 32'd0;
   assign in_mmio  = addr[31:4] == MMIO_BASE[31:4];
   assign word_idx = addr[AW+1:2];
   assign reg_sel  = addr[3:2];
   assign f3_legal = (bus.func3 == 3'b000) || (bus.func3 == 3'b001) || (bus.func3 == 3'b010);
   assign misaligned = ((bus.func3 == 3'b001) && addr[0]) ||
                       ((bus.func3 == 3'b010) && (addr[1:0] != 2'b00));

   assign status = {15'd0, halt_q, 6'd0, illegal_q, unmapped_q, mis_cnt_q};

   // Lane enables and replicated store data; replication lets every enabled
   // lane pick its byte from the same bit position of wd.
   always_comb begin
      be = 4'b0000;
      wd = 32'd0;
      case (bus.func3)
         3'b000: begin
            be = 4'b0001 << addr[1:0];
            wd = {4{bus.data_to_write[7:0]}};
         end
         3'b001: begin
            be = addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{bus.data_to_write[15:0]}};
         end
         3'b010: begin
            be = 4'b1111;
            wd = bus.data_to_write;
         end
         default: begin
            be = 4'b0000;
            wd = 32'd0;
         end
      endcase
   end

   // rst gates the RAM write because the array itself has no reset branch.
   assign ram_we = bus.write_data && (state_q == ST_RUN) && f3_legal &&
                   !misaligned && in_ram && !rst;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[word_idx][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   // Combinational read; pre-edge contents are visible when a store is pending.
   always_comb begin
      rd = 32'd0;
      if (in_ram) begin
         rd = mem_q[word_idx];
      end else if (in_mmio) begin
         case (reg_sel)
            2'd0:    rd = cycle_q[31:0];
            2'd1:    rd = cycle_q[63:32];
            2'd2:    rd = tohost_q;
            default: rd = status;
         endcase
      end
   end

   // Store classification priority: illegal func3, then alignment, then region.
   always_comb begin
      state_d    = state_q;
      cycle_d    = cycle_q;
      tohost_d   = tohost_q;
      mis_cnt_d  = mis_cnt_q;
      unmapped_d = unmapped_q;
      illegal_d  = illegal_q;
      err_d      = err_q;
      if (state_q == ST_RUN) begin
         cycle_d = cycle_q + 64'd1;
         if (bus.write_data) begin
            if (!f3_legal) begin
               illegal_d = 1'b1;
               err_d     = 1'b1;
            end else if (misaligned) begin
               if (mis_cnt_q != 8'hFF) mis_cnt_d = mis_cnt_q + 8'd1;
               err_d = 1'b1;
            end else if (in_ram) begin
               err_d = err_q;
            end else if (in_mmio) begin
               if ((bus.func3 == 3'b010) && (reg_sel == 2'd2)) begin
                  tohost_d = bus.data_to_write;
                  if (bus.data_to_write != 32'd0) state_d = ST_HALTED;
               end
            end else begin
               unmapped_d = 1'b1;
               err_d      = 1'b1;
            end
         end
      end
      halt_d = (state_d == ST_HALTED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         halt_q     <= 1'b0;
         cycle_q    <= 64'd0;
         tohost_q   <= 32'd0;
         mis_cnt_q  <= 8'd0;
         unmapped_q <= 1'b0;
         illegal_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         halt_q     <= halt_d;
         cycle_q    <= cycle_d;
         tohost_q   <= tohost_d;
         mis_cnt_q  <= mis_cnt_d;
         unmapped_q <= unmapped_d;
         illegal_q  <= illegal_d;
         err_q      <= err_d;
      end
   end

   assign bus.read_data    = rd;
   assign bus.halt         = halt_q;
   assign bus.tohost_value = tohost_q;
   assign bus.store_error  = err_q;
endmodule

// File: tb/tb_dmem_subsystem.sv
// tb/tb_dmem_subsystem.sv - self-checking bench for dmem_subsystem
module tb_dmem_subsystem;
   localparam logic [31:0] MB      = 32'hFFFF_0000;
   localparam logic [31:0] A_CLO   = MB + 32'h0;
   localparam logic [31:0] A_CHI   = MB + 32'h4;
   localparam logic [31:0] A_TOH   = MB + 32'h8;
   localparam logic [31:0] A_STAT  = MB + 32'hC;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_subsystem_if bus();

   dmem_subsystem #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  f3;
      logic [31:0] exp;
      string       nm;
   } vec_t;

   typedef struct {
      string       nm;
      logic [31:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic sb_pop();
      sb_t it;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         it = sb_q.pop_front();
         chk(it.nm, {32'd0, bus.read_data}, {32'd0, it.exp});
      end
   endtask

   // Read: drive the address, queue the expectation, sample 1 ns later.
   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
      bus.memory_address = a;
      bus.write_data     = 1'b0;
      sb_q.push_back('{nm, exp});
      #1;
      sb_pop();
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      bus.memory_address = a;
      bus.data_to_write  = d;
      bus.func3          = f3;
      bus.write_data     = 1'b1;
   endtask

   task automatic add(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input logic [31:0] exp, input string nm);
      vecs.push_back('{we, a, d, f3, exp, nm});
   endtask

   initial begin
      bus.memory_address = 32'd0;
      bus.data_to_write  = 32'd0;
      bus.func3          = 3'b010;
      bus.write_data     = 1'b0;

      add(1, 32'h0,         32'h1234_5678, 3'b010, 0, "");
      add(1, 32'h10,        32'h1122_3344, 3'b010, 0, "");
      add(1, 32'h11,        32'hFFFF_FFAA, 3'b000, 0, "");
      add(1, 32'h12,        32'h1234_BEEF, 3'b001, 0, "");
      add(0, 32'h10,        0, 0, 32'hBEEF_AA44, "lane_merge");
      add(0, 32'h13,        0, 0, 32'hBEEF_AA44, "aligned_word_rd");
      add(1, 32'h20,        32'hCAFE_F00D, 3'b010, 0, "");
      add(1, 32'h21,        32'h0000_5555, 3'b001, 0, "");
      add(1, 32'h22,        32'h9999_9999, 3'b010, 0, "");
      add(1, 32'h20,        32'h7777_7777, 3'b011, 0, "");
      add(0, 32'h20,        0, 0, 32'hCAFE_F00D, "misaligned_dropped");
      add(0, A_STAT,        0, 0, 32'h0000_0202, "status_mis_illegal");
      add(1, 32'h4000_0000, 32'hFFFF_FFFF, 3'b010, 0, "");
      add(0, 32'h4000_0000, 0, 0, 32'h0, "unmapped_rd");
      add(0, A_STAT,        0, 0, 32'h0000_0302, "status_unmapped");
      add(1, 32'hFFC,       32'h0, 3'b010, 0, "");
      add(1, 32'hFFF,       32'h0000_0077, 3'b000, 0, "");
      add(0, 32'hFFC,       0, 0, 32'h7700_0000, "ram_top_byte");
      add(1, 32'h1000,      32'hABCD_0123, 3'b010, 0, "");
      add(0, 32'h1000,      0, 0, 32'h0, "past_ram_rd");
      add(1, A_TOH,         32'h5, 3'b000, 0, "");
      add(1, A_CLO,         32'h5, 3'b010, 0, "");
      add(0, A_TOH,         0, 0, 32'h0, "tohost_sb_ignored");
      add(0, A_STAT,        0, 0, 32'h0000_0302, "status_mmio_no_err");
      add(0, 32'h0,         0, 0, 32'h1234_5678, "ram0_rd");

      // Reset state and counter start after release.
      repeat (2) @(negedge clk);
      chk("rst_halt", {63'd0, bus.halt}, 64'd0);
      chk("rst_err", {63'd0, bus.store_error}, 64'd0);
      chk("rst_tohost", {32'd0, bus.tohost_value}, 64'd0);
      rd(A_STAT, 32'h0, "rst_status");
      rst = 1'b0;
      rd(A_CLO, 32'd0, "cycle_first");
      repeat (10) @(negedge clk);
      rd(A_CLO, 32'd10, "cycle_10");
      rd(A_CHI, 32'd0, "cycle_hi_0");

      // Carry from low to high word, then full 64-bit wrap.
      @(negedge clk);
      force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
      #1 release dut.cycle_q;
      rd(A_CLO, 32'hFFFF_FFFF, "cycle_forced");
      @(negedge clk);
      rd(A_CLO, 32'd0, "cycle_carry_lo");
      rd(A_CHI, 32'd1, "cycle_carry_hi");
      @(negedge clk);
      force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.cycle_q;
      @(negedge clk);
      rd(A_CLO, 32'd0, "cycle_wrap_lo");
      rd(A_CHI, 32'd0, "cycle_wrap_hi");

      // Table-driven stores and reads.
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         if (vecs[i].we) st(vecs[i].addr, vecs[i].data, vecs[i].f3);
         else rd(vecs[i].addr, vecs[i].exp, vecs[i].nm);
      end
      @(negedge clk);
      bus.write_data = 1'b0;
      chk("store_error_set", {63'd0, bus.store_error}, 64'd1);
      chk("no_halt_yet", {63'd0, bus.halt}, 64'd0);

      // Halt: zero to TOHOST does not halt, nonzero does.
      @(negedge clk);
      st(A_TOH, 32'h0, 3'b010);
      @(negedge clk);
      bus.write_data = 1'b0;
      chk("halt_zero", {63'd0, bus.halt}, 64'd0);
      @(negedge clk);
      force dut.cycle_q = 64'd1000;
      #1 release dut.cycle_q;
      st(A_TOH, 32'h1, 3'b010);
      @(negedge clk);
      bus.write_data = 1'b0;
      chk("halt_set", {63'd0, bus.halt}, 64'd1);
      chk("tohost_1", {32'd0, bus.tohost_value}, 64'd1);
      rd(A_CLO, 32'd1001, "cycle_at_halt");
      @(negedge clk);
      st(32'h0, 32'h55, 3'b010);
      @(negedge clk);
      st(A_TOH, 32'h2, 3'b010);
      @(negedge clk);
      st(32'h1, 32'h0, 3'b001);
      @(negedge clk);
      bus.write_data = 1'b0;
      rd(32'h0, 32'h1234_5678, "halted_store_dropped");
      chk("halted_tohost_kept", {32'd0, bus.tohost_value}, 64'd1);
      rd(A_STAT, 32'h0001_0302, "halted_status");
      rd(A_CLO, 32'd1001, "cycle_frozen");

      // Asynchronous reset mid-cycle, then reset held across a store edge.
      @(negedge clk);
      bus.memory_address = A_STAT;
      #1 rst = 1'b1;
      #1;
      chk("arst_halt", {63'd0, bus.halt}, 64'd0);
      chk("arst_err", {63'd0, bus.store_error}, 64'd0);
      rd(A_STAT, 32'h0, "arst_status");
      rd(A_CLO, 32'h0, "arst_cycle");
      st(32'h10, 32'hDEAD_0000, 3'b010);
      @(negedge clk);
      rst = 1'b0;
      bus.write_data = 1'b0;
      rd(32'h10, 32'hBEEF_AA44, "ram_kept_store_dropped");
      rd(32'h0, 32'h1234_5678, "ram0_kept");
      rd(A_CLO, 32'd0, "release_cycle0");
      @(negedge clk);
      rd(A_CLO, 32'd1, "release_cycle1");

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
